// File: rtl/adder_exerciser.sv
// Self-checking exerciser for a WIDTH-bit full adder: sweeps {c_in, b, a}, compares
// {c_out, sum} against a + b + c_in. Optional macro: ADDER_EXERCISER_STOP_ON_ERR_EN.
module adder_exerciser #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic               c_in,
  input  logic [WIDTH-1:0]   sum,
  input  logic               c_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [15:0]        err_count,
  output logic [2*WIDTH:0]   first_err_vec
);

  localparam int VW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [VW-1:0]     vec_q, vec_d;
  logic [3:0]        settle_q, settle_d;
  logic [15:0]       err_count_q, err_count_d;
  logic [VW-1:0]     first_err_q, first_err_d;
  logic              pass_q, pass_d;
  logic [WIDTH:0]    exp_val;
  logic              mismatch;

  // The reference is one bit wider than the operands so the carry is never lost.
  always_comb begin
    exp_val  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
    mismatch = ({c_out, sum} != exp_val);
  end

  // NOTE: every *_d gets its hold value first, so no path through the case leaves a latch.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    settle_d    = settle_q;
    err_count_d = err_count_q;
    first_err_d = first_err_q;
    pass_d      = pass_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_WAIT;
          vec_d       = '0;
          settle_d    = '0;
          err_count_d = '0;
          first_err_d = '0;
          pass_d      = 1'b0;
        end
      end

      S_WAIT: begin
        if (settle_q == 4'(SETTLE_CYCLES - 1)) begin
          state_d = S_CHECK;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end

      S_CHECK: begin
        settle_d = '0;
        if (mismatch) begin
          if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
          if (err_count_q == 16'd0)    first_err_d = vec_q;
        end
        if (vec_q == '1) begin
          state_d = S_DONE;
          pass_d  = !mismatch && (err_count_q == 16'd0);
`ifdef ADDER_EXERCISER_STOP_ON_ERR_EN
        end else if (mismatch) begin
          // Freeze on the failing vector so it stays driven for inspection.
          state_d = S_DONE;
          pass_d  = 1'b0;
`endif
        end else begin
          state_d = S_WAIT;
          vec_d   = vec_q + {{(VW-1){1'b0}}, 1'b1};
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      vec_q       <= '0;
      settle_q    <= '0;
      err_count_q <= '0;
      first_err_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      settle_q    <= settle_d;
      err_count_q <= err_count_d;
      first_err_q <= first_err_d;
      pass_q      <= pass_d;
    end
  end

  assign {c_in, b, a}  = vec_q;
  assign busy          = (state_q == S_WAIT) || (state_q == S_CHECK);
  assign done          = (state_q == S_DONE);
  assign pass          = pass_q;
  assign err_count     = err_count_q;
  assign first_err_vec = first_err_q;

endmodule

// File: tb/tb_adder_exerciser.sv
// Bench for adder_exerciser: a configurable (optionally faulty) adder model answers the
// exerciser; expected counts come from an arithmetic sweep over the whole vector space.
module tb_adder_exerciser;

  localparam int W     = 4;
  localparam int SC    = 2;
  localparam int NVEC  = 512;
  localparam int SWEEP = NVEC * (SC + 1);
`ifdef ADDER_EXERCISER_STOP_ON_ERR_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a, b, sum;
  logic         c_in, c_out;
  logic         busy, done, pass;
  logic [15:0]  err_count;
  logic [8:0]   first_err_vec;

  int vectors     = 0;
  int miscompares = 0;

  // Fault description of the adder under test: 0 none, 1 stuck-at-0, 2 stuck-at-1, 3 xor on match.
  int         f_kind = 0;
  int         f_bit  = 0;
  logic [8:0] f_mask = '0;
  logic [8:0] f_val  = '0;
  logic [4:0] f_xor  = '0;

  always #5 clk = ~clk;

  adder_exerciser #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .a             (a),
    .b             (b),
    .c_in          (c_in),
    .sum           (sum),
    .c_out         (c_out),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_vec (first_err_vec)
  );

  function automatic logic [4:0] adder_resp(input logic [8:0] v, input int kind, input int bit_i,
                                            input logic [8:0] m, input logic [8:0] val,
                                            input logic [4:0] x);
    int         s;
    logic [4:0] r;
    s = int'(v[3:0]) + int'(v[7:4]) + int'(v[8]);
    r = 5'(s);
    case (kind)
      1:       r[bit_i] = 1'b0;
      2:       r[bit_i] = 1'b1;
      3:       if ((v & m) == val) r = r ^ x;
      default: ;
    endcase
    return r;
  endfunction

  always_comb {c_out, sum} = adder_resp({c_in, b, a}, f_kind, f_bit, f_mask, f_val, f_xor);

  task automatic model_sweep(output int errs, output logic [8:0] first);
    errs  = 0;
    first = '0;
    for (int v = 0; v < NVEC; v++) begin
      logic [8:0] vv;
      vv = 9'(v);
      if (int'(adder_resp(vv, f_kind, f_bit, f_mask, f_val, f_xor)) != v % 16 + (v / 16) % 16 + v / 256) begin
        if (errs == 0) first = vv;
        errs++;
      end
    end
  endtask

  // Pulses start, then follows the sweep to done and compares timing and results.
  task automatic do_sweep(input string tag, input bit poke_start, input int exp_errs,
                          input logic [8:0] exp_first);
    int          cycles;
    int          want_cycles;
    int          want_err;
    logic [8:0]  want_end;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    vectors++;
    if ({busy, done, pass} !== 3'b100 || {c_in, b, a} !== 9'h000) begin
      miscompares++;
      $display("FAIL %s start_latency: busy/done/pass=%b vec=%h, want 100 vec=000", tag,
               {busy, done, pass}, {c_in, b, a});
    end
    vectors++;
    if (err_count !== 16'd0 || first_err_vec !== 9'h000) begin
      miscompares++;
      $display("FAIL %s start_clear: err_count=%0d first=%h, want 0 000", tag, err_count, first_err_vec);
    end
    cycles = 0;
    while (done !== 1'b1 && cycles < SWEEP + 100) begin
      start = poke_start && (cycles == 10 || cycles == 500);
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;

    if (STOP_EN && exp_errs > 0) begin
      want_cycles = (int'(exp_first) + 1) * (SC + 1);
      want_err    = 1;
      want_end    = exp_first;
    end else begin
      want_cycles = SWEEP;
      want_err    = (exp_errs > 65535) ? 65535 : exp_errs;
      want_end    = 9'h1FF;
    end

    vectors++;
    if (cycles != want_cycles) begin
      miscompares++;
      $display("FAIL %s done_timing: %0d cycles, want %0d", tag, cycles, want_cycles);
    end
    vectors++;
    if (int'(err_count) != want_err) begin
      miscompares++;
      $display("FAIL %s err_count: got %0d, want %0d", tag, err_count, want_err);
    end
    vectors++;
    if (first_err_vec !== exp_first) begin
      miscompares++;
      $display("FAIL %s first_err_vec: got %h, want %h", tag, first_err_vec, exp_first);
    end
    vectors++;
    if (pass !== (exp_errs == 0) || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s pass/busy: got %b%b, want %b0", tag, pass, busy, exp_errs == 0);
    end
    vectors++;
    if ({c_in, b, a} !== want_end) begin
      miscompares++;
      $display("FAIL %s end_vec: got %h, want %h", tag, {c_in, b, a}, want_end);
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    start  = 1'b0;
    f_kind = 0;
    #1;
    vectors++;
    if ({busy, done, pass, c_in, b, a} !== 12'h000 || err_count !== 16'd0 || first_err_vec !== 9'h000) begin
      miscompares++;
      $display("FAIL reset_values: busy/done/pass=%b vec=%h err=%0d first=%h, want all zero",
               {busy, done, pass}, {c_in, b, a}, err_count, first_err_vec);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy/done=%b, want 00", {busy, done});
    end
  endtask

  task automatic test_correct_adder();
    f_kind = 0;
    do_sweep("correct", 1'b0, 0, 9'h000);
  endtask

  task automatic test_sum0_stuck();
    f_kind = 1;
    f_bit  = 0;
    do_sweep("sum0_stuck", 1'b0, 256, 9'h001);
  endtask

  task automatic test_cout_stuck();
    f_kind = 1;
    f_bit  = 4;
    do_sweep("cout_stuck", 1'b0, 256, 9'h01F);
  endtask

  task automatic test_reset_mid_sweep();
    f_kind = 3;
    f_mask = 9'h000;
    f_val  = 9'h000;
    f_xor  = 5'h01;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (700) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({busy, done, pass, c_in, b, a} !== 12'h000 || err_count !== 16'd0 || first_err_vec !== 9'h000) begin
      miscompares++;
      $display("FAIL mid_sweep_reset: busy/done/pass=%b vec=%h err=%0d first=%h, want all zero",
               {busy, done, pass}, {c_in, b, a}, err_count, first_err_vec);
    end
    @(negedge clk) reset = 1'b0;
    f_kind = 0;
    do_sweep("after_reset", 1'b0, 0, 9'h000);
  endtask

  task automatic test_start_ignored();
    f_kind = 0;
    do_sweep("start_ignored", 1'b1, 0, 9'h000);
  endtask

  task automatic test_back_to_back();
    f_kind = 1;
    f_bit  = 0;
    do_sweep("b2b_faulty", 1'b0, 256, 9'h001);
    f_kind = 0;
    do_sweep("b2b_restart", 1'b0, 0, 9'h000);
  endtask

  task automatic test_random_faults();
    int         errs;
    logic [8:0] first;
    for (int i = 0; i < 5; i++) begin
      f_kind = int'($urandom_range(1, 3));
      f_bit  = int'($urandom_range(0, 4));
      f_mask = 9'($urandom);
      f_val  = 9'($urandom) & f_mask;
      f_xor  = 5'($urandom_range(1, 31));
      model_sweep(errs, first);
      do_sweep($sformatf("random%0d_k%0d", i, f_kind), 1'b0, errs, first);
    end
  endtask

  initial begin
    test_reset();
    test_correct_adder();
    test_sum0_stuck();
    test_cout_stuck();
    test_reset_mid_sweep();
    test_start_ignored();
    test_back_to_back();
    test_random_faults();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
